// File: rtl/lfsr_prng_8_pkg.sv
// Shared types, defaults and the step function for the 8-bit LFSR pseudo-random source.
package lfsr_pkg;

  localparam int unsigned LFSR_W = 8;

  typedef logic [LFSR_W-1:0] lfsr_t;

  localparam lfsr_t       TAPS_DEFAULT            = 8'hB8;  // x^8+x^6+x^5+x^4+1
  localparam lfsr_t       DEFAULT_SEED_DEFAULT    = 8'h01;
  localparam int unsigned AUTO_DIV_DEFAULT        = 12_500_000;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500_000;

  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } mode_t;

  // Fibonacci step: shift left, feedback is the parity of the tapped bits.
  function automatic lfsr_t lfsr_next(input lfsr_t state, input lfsr_t taps);
    return {state[LFSR_W-2:0], ^(state & taps)};
  endfunction

endpackage

// File: rtl/lfsr_prng_8_key_conditioner.sv
// Push-button conditioner: 2-FF synchroniser, optional debounce and press (falling-edge) pulse.
// Debounce counter is present only when STEP_DEBOUNCE_EN is defined.
module key_conditioner
  import lfsr_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
  output logic press_o
);

  logic [1:0] sync_q;
  logic       prev_q;
  logic       level;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[0], key_i};
    end
  end

`ifdef STEP_DEBOUNCE_EN
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;

  // The counter only runs while the synchronised input disagrees with the
  // accepted level, so any bounce back restarts the qualification window.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      level_d = sync_q[1];
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      level_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;
`else
  logic unused_debounce;
  assign unused_debounce = (DEBOUNCE_CYCLES == 0);
  assign level           = sync_q[1];
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= level;
    end
  end

  assign press_o = prev_q & ~level;

endmodule

// File: rtl/lfsr_prng_8.sv
// 8-bit Fibonacci LFSR stepped by key press or auto-run divider, seed loadable from switches.
// Build with STEP_DEBOUNCE_EN to debounce StepKey.
module lfsr_prng_8
  import lfsr_pkg::*;
#(
  parameter lfsr_t       TAPS            = TAPS_DEFAULT,
  parameter lfsr_t       DEFAULT_SEED    = DEFAULT_SEED_DEFAULT,
  parameter int unsigned AUTO_DIV        = AUTO_DIV_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic [LFSR_W-1:0] SeedIn,
  input  logic              LoadSeed,
  input  logic              StepKey,
  input  logic              AutoRun,
  output logic [LFSR_W-1:0] RandomOut,
  output logic              Valid,
  output logic [15:0]       StepCount
);

  localparam int unsigned      DIV_W    = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(AUTO_DIV - 1);

  logic [1:0]       rst_sync_q;
  logic             rst_n;
  logic [1:0]       load_sync_q;
  logic [1:0]       auto_sync_q;
  logic             load_prev_q;
  logic             load_evt;
  logic             key_press;
  logic             tick;
  lfsr_t            seed_sel;
  lfsr_t            state_q, state_d;
  logic             valid_q, valid_d;
  logic [15:0]      count_q, count_d;
  logic [DIV_W-1:0] div_q, div_d;
  mode_t            mode_q, mode_d;

  // Reset asserts immediately but is released in step with Clock.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  always_ff @(posedge Clock or negedge rst_n) begin
    if (!rst_n) begin
      load_sync_q <= '0;
      auto_sync_q <= '0;
      load_prev_q <= 1'b0;
    end else begin
      load_sync_q <= {load_sync_q[0], LoadSeed};
      auto_sync_q <= {auto_sync_q[0], AutoRun};
      load_prev_q <= load_sync_q[1];
    end
  end

  assign load_evt = load_sync_q[1] & ~load_prev_q;

  key_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key (
    .clk_i  (Clock),
    .rst_ni (rst_n),
    .key_i  (StepKey),
    .press_o(key_press)
  );

  assign seed_sel = (SeedIn == '0) ? DEFAULT_SEED : SeedIn;

  always_comb begin
    mode_d  = mode_q;
    div_d   = div_q;
    tick    = 1'b0;
    state_d = state_q;
    count_d = count_q;
    valid_d = 1'b0;

    case (mode_q)
      MANUAL: begin
        if (auto_sync_q[1]) mode_d = AUTO;
      end
      AUTO: begin
        if (!auto_sync_q[1]) begin
          mode_d = MANUAL;
          div_d  = '0;
        end else if (div_q == DIV_LAST) begin
          div_d = '0;
          tick  = 1'b1;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: mode_d = MANUAL;
    endcase

    // A load overrides any step; a key press coinciding with a tick is one step.
    if (load_evt) begin
      state_d = seed_sel;
      count_d = '0;
      div_d   = '0;
      valid_d = 1'b1;
    end else if (key_press || tick) begin
      state_d = lfsr_next(state_q, TAPS);
      count_d = count_q + 16'd1;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MANUAL;
      div_q   <= '0;
      state_q <= DEFAULT_SEED;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      div_q   <= div_d;
      state_q <= state_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  assign RandomOut = state_q;
  assign Valid     = valid_q;
  assign StepCount = count_q;

endmodule

// File: tb/tb_lfsr_prng_8.sv
// Self-checking bench for lfsr_prng_8: scoreboard of expected (value, count) pairs popped on Valid.
`timescale 1ns/1ps
module tb_lfsr_prng_8;

  localparam int unsigned AUTO_DIV        = 4;
  localparam int unsigned DEBOUNCE_CYCLES = 8;
`ifdef STEP_DEBOUNCE_EN
  localparam int KEY_LAT = 3 + DEBOUNCE_CYCLES;
`else
  localparam int KEY_LAT = 3;
`endif
  localparam int LOAD_LAT = 3;
  localparam int AUTO_LAT = 7;
  localparam int HOLD     = 12;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic [7:0]  SeedIn;
  logic        LoadSeed;
  logic        StepKey;
  logic        AutoRun;
  logic [7:0]  RandomOut;
  logic        Valid;
  logic [15:0] StepCount;

  typedef struct packed {
    logic [7:0]  v;
    logic [15:0] c;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [7:0]  model;
  logic [15:0] mcount;
  int          checks   = 0;
  int          failures = 0;

  lfsr_prng_8 #(
    .AUTO_DIV       (AUTO_DIV),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) dut (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
    .SeedIn   (SeedIn),
    .LoadSeed (LoadSeed),
    .StepKey  (StepKey),
    .AutoRun  (AutoRun),
    .RandomOut(RandomOut),
    .Valid    (Valid),
    .StepCount(StepCount)
  );

  always #5 Clock = ~Clock;

  function automatic logic [7:0] ref_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  task automatic expect_step();
    model  = ref_next(model);
    mcount = mcount + 16'd1;
    sb.push_back({model, mcount});
  endtask

  task automatic expect_load(input logic [7:0] v);
    model  = (v == 8'h00) ? 8'h01 : v;
    mcount = 16'd0;
    sb.push_back({model, mcount});
  endtask

  task automatic test_reset();
    Reset_n  = 1'b0;
    SeedIn   = 8'h00;
    LoadSeed = 1'b0;
    StepKey  = 1'b1;
    AutoRun  = 1'b0;
    repeat (3) @(negedge Clock);
    checks++;
    if (RandomOut !== 8'h01) begin failures++; $display("FAIL reset_random got=%h exp=01", RandomOut); end
    checks++;
    if (Valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", Valid); end
    checks++;
    if (StepCount !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", StepCount); end
    Reset_n = 1'b1;
    repeat (5) @(negedge Clock);
    model  = 8'h01;
    mcount = 16'd0;
    sb.delete();
  endtask

  task automatic test_manual_steps();
    int seen;
    int at;
    for (int p = 0; p < 4; p++) begin
      seen = 0;
      at   = -1;
      expect_step();
      StepKey = 1'b0;
      for (int cyc = 1; cyc <= 2 * HOLD; cyc++) begin
        @(negedge Clock);
        if (cyc == HOLD) StepKey = 1'b1;
        if (Valid === 1'b1) begin
          seen++;
          at = cyc;
          checks++;
          if (sb.size() == 0) begin
            failures++; $display("FAIL manual_extra_valid got=%h exp=none", RandomOut);
          end else begin
            e = sb.pop_front();
            if (RandomOut !== e.v || StepCount !== e.c) begin
              failures++; $display("FAIL manual_step got=%h/%0d exp=%h/%0d", RandomOut, StepCount, e.v, e.c);
            end
          end
        end
      end
      checks++;
      if (seen != 1 || at != KEY_LAT) begin
        failures++; $display("FAIL manual_pulse got=%0d pulses at %0d exp=1 at %0d", seen, at, KEY_LAT);
      end
    end
    checks++;
    if (RandomOut !== 8'h11 || StepCount !== 16'd4) begin
      failures++; $display("FAIL manual_final got=%h/%0d exp=11/4", RandomOut, StepCount);
    end
  endtask

  task automatic test_load();
    int seen;
    int at;
    seen = 0;
    at   = -1;
    SeedIn   = 8'hA5;
    LoadSeed = 1'b1;
    expect_load(8'hA5);
    for (int cyc = 1; cyc <= 2 * HOLD; cyc++) begin
      @(negedge Clock);
      if (cyc == HOLD) LoadSeed = 1'b0;
      if (Valid === 1'b1) begin
        seen++;
        at = cyc;
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL load_extra_valid got=%h exp=none", RandomOut);
        end else begin
          e = sb.pop_front();
          if (RandomOut !== e.v || StepCount !== e.c) begin
            failures++; $display("FAIL load_a5 got=%h/%0d exp=%h/%0d", RandomOut, StepCount, e.v, e.c);
          end
        end
      end
    end
    checks++;
    if (seen != 1 || at != LOAD_LAT) begin
      failures++; $display("FAIL load_pulse got=%0d pulses at %0d exp=1 at %0d", seen, at, LOAD_LAT);
    end

    // Zero seed loads the default; LoadSeed is then held while a key steps.
    seen     = 0;
    SeedIn   = 8'h00;
    LoadSeed = 1'b1;
    expect_load(8'h00);
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge Clock);
      if (cyc == HOLD) begin StepKey = 1'b0; expect_step(); end
      if (cyc == 2 * HOLD) StepKey = 1'b1;
      if (cyc == 45) LoadSeed = 1'b0;
      if (Valid === 1'b1) begin
        seen++;
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL load_hold_extra_valid got=%h exp=none", RandomOut);
        end else begin
          e = sb.pop_front();
          if (RandomOut !== e.v || StepCount !== e.c) begin
            failures++; $display("FAIL load_hold got=%h/%0d exp=%h/%0d", RandomOut, StepCount, e.v, e.c);
          end
        end
      end
    end
    checks++;
    if (seen != 2 || RandomOut !== 8'h02) begin
      failures++; $display("FAIL load_hold_pulses got=%0d/%h exp=2/02", seen, RandomOut);
    end
  endtask

  task automatic test_full_period();
    bit seen_v [256];
    int dups;
    int seen;
    dups = 0;
    for (int i = 0; i < 256; i++) seen_v[i] = 1'b0;
    SeedIn   = 8'h01;
    LoadSeed = 1'b1;
    expect_load(8'h01);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge Clock);
      if (cyc == 5) LoadSeed = 1'b0;
      if (Valid === 1'b1 && sb.size() != 0) e = sb.pop_front();
    end
    checks++;
    if (RandomOut !== 8'h01 || StepCount !== 16'd0 || sb.size() != 0) begin
      failures++; $display("FAIL period_seed got=%h/%0d exp=01/0", RandomOut, StepCount);
    end
    for (int p = 0; p < 255; p++) begin
      seen = 0;
      expect_step();
      StepKey = 1'b0;
      for (int cyc = 1; cyc <= 2 * HOLD; cyc++) begin
        @(negedge Clock);
        if (cyc == HOLD) StepKey = 1'b1;
        if (Valid === 1'b1) begin
          seen++;
          checks++;
          if (RandomOut == 8'h00 || seen_v[RandomOut]) dups++;
          seen_v[RandomOut] = 1'b1;
          if (sb.size() == 0) begin
            failures++; $display("FAIL period_extra_valid got=%h exp=none", RandomOut);
          end else begin
            e = sb.pop_front();
            if (RandomOut !== e.v || StepCount !== e.c) begin
              failures++; $display("FAIL period_step got=%h/%0d exp=%h/%0d", RandomOut, StepCount, e.v, e.c);
            end
          end
        end
      end
      if (seen != 1) begin
        checks++; failures++; $display("FAIL period_pulse step=%0d got=%0d exp=1", p, seen);
      end
    end
    checks++;
    if (dups != 0) begin failures++; $display("FAIL period_distinct got=%0d repeats exp=0", dups); end
    checks++;
    if (RandomOut !== 8'h01 || StepCount !== 16'd255) begin
      failures++; $display("FAIL period_wrap got=%h/%0d exp=01/255", RandomOut, StepCount);
    end
  endtask

  task automatic test_auto();
    int seen;
    seen    = 0;
    AutoRun = 1'b1;
    for (int k = 0; k < 5; k++) expect_step();
    for (int cyc = 1; cyc <= AUTO_LAT + 16; cyc++) begin
      @(negedge Clock);
      if (Valid === 1'b1) begin
        checks++;
        if (cyc != AUTO_LAT + 4 * seen || sb.size() == 0) begin
          failures++; $display("FAIL auto_timing got=cycle %0d exp=cycle %0d", cyc, AUTO_LAT + 4 * seen);
        end else begin
          e = sb.pop_front();
          if (RandomOut !== e.v || StepCount !== e.c) begin
            failures++; $display("FAIL auto_step got=%h/%0d exp=%h/%0d", RandomOut, StepCount, e.v, e.c);
          end
        end
        seen++;
      end
      if (cyc == AUTO_LAT + 16) AutoRun = 1'b0;
    end
    checks++;
    if (seen != 5) begin failures++; $display("FAIL auto_count got=%0d exp=5", seen); end

    seen = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge Clock);
      if (Valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL auto_stop got=%0d steps exp=0", seen); end

    // Re-entry must take the full divider period again, proving it was cleared.
    seen    = 0;
    AutoRun = 1'b1;
    expect_step();
    for (int cyc = 1; cyc <= AUTO_LAT + 10; cyc++) begin
      @(negedge Clock);
      if (Valid === 1'b1) begin
        seen++;
        checks++;
        if (cyc != AUTO_LAT || sb.size() == 0) begin
          failures++; $display("FAIL auto_reentry got=cycle %0d exp=cycle %0d", cyc, AUTO_LAT);
        end else begin
          e = sb.pop_front();
          if (RandomOut !== e.v || StepCount !== e.c) begin
            failures++; $display("FAIL auto_reentry_step got=%h/%0d exp=%h/%0d", RandomOut, StepCount, e.v, e.c);
          end
        end
      end
      if (cyc == AUTO_LAT) AutoRun = 1'b0;
    end
    checks++;
    if (seen != 1) begin failures++; $display("FAIL auto_reentry_count got=%0d exp=1", seen); end
  endtask

  task automatic test_collision();
    int key_at;
    int auto_at;
    int load_at;
    int ev;
    int seen;
    int at;
    key_at  = (KEY_LAT >= AUTO_LAT) ? 0 : AUTO_LAT - KEY_LAT;
    auto_at = key_at + KEY_LAT - AUTO_LAT;
    ev      = key_at + KEY_LAT;
    seen    = 0;
    at      = -1;
    expect_step();
    for (int cyc = 0; cyc <= ev + 40; cyc++) begin
      if (cyc == key_at) StepKey = 1'b0;
      if (cyc == auto_at) AutoRun = 1'b1;
      if (cyc == ev) AutoRun = 1'b0;
      if (cyc == ev + HOLD) StepKey = 1'b1;
      @(negedge Clock);
      if (Valid === 1'b1) begin
        seen++;
        at = cyc + 1;
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL tick_key_extra got=%h exp=none", RandomOut);
        end else begin
          e = sb.pop_front();
          if (RandomOut !== e.v || StepCount !== e.c) begin
            failures++; $display("FAIL tick_key_step got=%h/%0d exp=%h/%0d", RandomOut, StepCount, e.v, e.c);
          end
        end
      end
    end
    checks++;
    if (seen != 1 || at != ev) begin
      failures++; $display("FAIL tick_key_once got=%0d at %0d exp=1 at %0d", seen, at, ev);
    end

    load_at = KEY_LAT - LOAD_LAT;
    seen    = 0;
    at      = -1;
    SeedIn  = 8'h3C;
    expect_load(8'h3C);
    for (int cyc = 0; cyc <= KEY_LAT + 40; cyc++) begin
      if (cyc == 0) StepKey = 1'b0;
      if (cyc == load_at) LoadSeed = 1'b1;
      if (cyc == KEY_LAT + 2) LoadSeed = 1'b0;
      if (cyc == KEY_LAT + HOLD) StepKey = 1'b1;
      @(negedge Clock);
      if (Valid === 1'b1) begin
        seen++;
        at = cyc + 1;
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL load_key_extra got=%h/%0d exp=none", RandomOut, StepCount);
        end else begin
          e = sb.pop_front();
          if (RandomOut !== e.v || StepCount !== e.c) begin
            failures++; $display("FAIL load_key_priority got=%h/%0d exp=%h/%0d", RandomOut, StepCount, e.v, e.c);
          end
        end
      end
    end
    checks++;
    if (seen != 1 || at != KEY_LAT) begin
      failures++; $display("FAIL load_key_once got=%0d at %0d exp=1 at %0d", seen, at, KEY_LAT);
    end
  endtask

`ifdef STEP_DEBOUNCE_EN
  task automatic test_debounce();
    int seen;
    seen = 0;
    for (int g = 0; g < 4; g++) begin
      StepKey = 1'b0;
      repeat (3) @(negedge Clock);
      if (Valid === 1'b1) seen++;
      StepKey = 1'b1;
      for (int cyc = 0; cyc < 3; cyc++) begin
        @(negedge Clock);
        if (Valid === 1'b1) seen++;
      end
    end
    for (int cyc = 0; cyc < 15; cyc++) begin
      @(negedge Clock);
      if (Valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL debounce_glitch got=%0d steps exp=0", seen); end

    seen = 0;
    expect_step();
    StepKey = 1'b0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge Clock);
      if (cyc == 10) StepKey = 1'b1;
      if (Valid === 1'b1) begin
        seen++;
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL debounce_extra got=%h exp=none", RandomOut);
        end else begin
          e = sb.pop_front();
          if (RandomOut !== e.v || StepCount !== e.c) begin
            failures++; $display("FAIL debounce_step got=%h/%0d exp=%h/%0d", RandomOut, StepCount, e.v, e.c);
          end
        end
      end
    end
    checks++;
    if (seen != 1) begin failures++; $display("FAIL debounce_press got=%0d steps exp=1", seen); end
  endtask
`endif

  task automatic test_reset_mid_auto();
    int seen;
    seen    = 0;
    AutoRun = 1'b1;
    StepKey = 1'b0;
    repeat (12) @(negedge Clock);
    #2 Reset_n = 1'b0;
    #1;
    checks++;
    if (RandomOut !== 8'h01 || Valid !== 1'b0 || StepCount !== 16'd0) begin
      failures++; $display("FAIL reset_mid_auto got=%h/%b/%0d exp=01/0/0", RandomOut, Valid, StepCount);
    end
    AutoRun = 1'b0;
    StepKey = 1'b1;
    repeat (3) @(negedge Clock);
    Reset_n = 1'b1;
    sb.delete();
    model  = 8'h01;
    mcount = 16'd0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge Clock);
      if (Valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0 || RandomOut !== 8'h01 || StepCount !== 16'd0) begin
      failures++; $display("FAIL reset_discard got=%0d steps %h/%0d exp=0 steps 01/0", seen, RandomOut, StepCount);
    end
  endtask

  initial begin
    test_reset();
    test_manual_steps();
    test_load();
    test_full_period();
    test_auto();
    test_collision();
`ifdef STEP_DEBOUNCE_EN
    test_debounce();
`endif
    test_reset_mid_auto();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_drain got=%0d pending exp=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
